rib_arbiter: RTL and testbench

RIB_ARBITER -- requirements
Module: rib_arbiter

---
 rtl/rib_arbiter_pkg.sv | 23 ++
 rtl/rib_rr_pick.sv | 27 ++
 rtl/rib_arbiter.sv | 137 +++++++++++++
 tb/tb_rib_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_arbiter_pkg.sv
// rtl/rib_arbiter_pkg.sv - shared state encoding, master indices and request bundle for the RIB arbiter
package rib_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } rib_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wrcs;
    logic [MASK_W-1:0] mask;
  } rib_req_t;

endpackage

// File: rtl/rib_rr_pick.sv
// rtl/rib_rr_pick.sv - two-way round-robin winner select; a tie goes to the master not served last
module rib_rr_pick
  import rib_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win_oh,
  output logic       win_idx,
  output logic       win_vld
);

  always_comb begin
    win_vld = |req;
    case (req)
      2'b01:   win_idx = M0;
      2'b10:   win_idx = M1;
      default: win_idx = ~last;
    endcase
    if (!win_vld)
      win_oh = 2'b00;
    else if (win_idx == M1)
      win_oh = 2'b10;
    else
      win_oh = 2'b01;
  end

endmodule

// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - two-master RIB arbiter with one outstanding transfer and slave timeout abort
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m0_wrcs,
  input  logic [3:0]  i_m0_mask,
  input  logic        i_m0_req,
  input  logic        i_m0_rdy,
  output logic        o_m0_gnt,
  output logic        o_m0_rsp,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic        i_m1_wrcs,
  input  logic [3:0]  i_m1_mask,
  input  logic        i_m1_req,
  input  logic        i_m1_rdy,
  output logic        o_m1_gnt,
  output logic        o_m1_rsp,
  output logic [31:0] o_m_rdata,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  output logic        o_s_wrcs,
  output logic [3:0]  o_s_mask,
  output logic        o_s_req,
  input  logic        i_s_gnt,
  input  logic        i_s_rsp,
  output logic        o_s_rdy,
  input  logic [31:0] i_s_rdata,
  output logic        o_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam bit              TO_EN   = (TIMEOUT != 0);

  rib_state_e      state, state_n;
  logic            owner;
  logic            last;
  logic [TO_W-1:0] cnt;

  rib_req_t   m0_f, m1_f, win_f;
  logic [1:0] win_oh;
  logic       win_idx;
  logic       win_vld;

  logic s_req_c, gnt0_c, gnt1_c, rsp0_c, rsp1_c, s_rdy_c;
  logic owner_rdy, done, expire, take;

  assign m0_f = '{addr: i_m0_addr, wdata: i_m0_wdata, wrcs: i_m0_wrcs, mask: i_m0_mask};
  assign m1_f = '{addr: i_m1_addr, wdata: i_m1_wdata, wrcs: i_m1_wrcs, mask: i_m1_mask};

  rib_rr_pick u_pick (
    .req     ({i_m1_req, i_m0_req}),
    .last    (last),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign win_f = (win_idx == M1) ? m1_f : m0_f;

  always_comb begin
    state_n   = state;
    s_req_c   = 1'b0;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    rsp0_c    = 1'b0;
    rsp1_c    = 1'b0;
    s_rdy_c   = 1'b0;
    owner_rdy = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        s_req_c = win_vld;
        gnt0_c  = win_oh[0] & i_s_gnt;
        gnt1_c  = win_oh[1] & i_s_gnt;
        take    = win_vld & i_s_gnt;
        if (take)
          state_n = ST_BUSY;
      end
      ST_BUSY: begin
        owner_rdy = (owner == M1) ? i_m1_rdy : i_m0_rdy;
        rsp0_c    = (owner == M0) & i_s_rsp;
        rsp1_c    = (owner == M1) & i_s_rsp;
        s_rdy_c   = owner_rdy;
        done      = i_s_rsp & owner_rdy;
        // A response in the expiry cycle wins over the abort.
        expire    = TO_EN && (cnt == TO_LAST) && !i_s_rsp;
        if (done || expire)
          state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
      owner <= M0;
      last  <= M1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        owner <= win_idx;
        last  <= win_idx;
        cnt   <= '0;
      end else if (state == ST_BUSY && !done && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Handshake outputs are forced low during reset even though the paths are combinational.
  assign o_s_req   = s_req_c & ~i_rst;
  assign o_m0_gnt  = gnt0_c  & ~i_rst;
  assign o_m1_gnt  = gnt1_c  & ~i_rst;
  assign o_m0_rsp  = rsp0_c  & ~i_rst;
  assign o_m1_rsp  = rsp1_c  & ~i_rst;
  assign o_s_rdy   = s_rdy_c & ~i_rst;
  assign o_err     = expire  & ~i_rst;

  assign o_s_addr  = win_f.addr;
  assign o_s_wdata = win_f.wdata;
  assign o_s_wrcs  = win_f.wrcs;
  assign o_s_mask  = win_f.mask;
  assign o_m_rdata = i_s_rdata;

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - directed and randomized bench for rib_arbiter against a transaction-level model
module tb_rib_arbiter;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata, i_s_rdata;
  logic        i_m0_wrcs, i_m0_req, i_m0_rdy, i_m1_wrcs, i_m1_req, i_m1_rdy;
  logic [3:0]  i_m0_mask, i_m1_mask;
  logic        i_s_gnt, i_s_rsp;
  logic        o_m0_gnt, o_m0_rsp, o_m1_gnt, o_m1_rsp, o_s_wrcs, o_s_req, o_s_rdy, o_err;
  logic [31:0] o_m_rdata, o_s_addr, o_s_wdata;
  logic [3:0]  o_s_mask;

  int checks = 0;
  int errors = 0;

  rib_arbiter #(.TIMEOUT(TO), .TO_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata), .i_m0_wrcs(i_m0_wrcs), .i_m0_mask(i_m0_mask),
    .i_m0_req(i_m0_req), .i_m0_rdy(i_m0_rdy), .o_m0_gnt(o_m0_gnt), .o_m0_rsp(o_m0_rsp),
    .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata), .i_m1_wrcs(i_m1_wrcs), .i_m1_mask(i_m1_mask),
    .i_m1_req(i_m1_req), .i_m1_rdy(i_m1_rdy), .o_m1_gnt(o_m1_gnt), .o_m1_rsp(o_m1_rsp),
    .o_m_rdata(o_m_rdata), .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata), .o_s_wrcs(o_s_wrcs),
    .o_s_mask(o_s_mask), .o_s_req(o_s_req), .i_s_gnt(i_s_gnt), .i_s_rsp(i_s_rsp),
    .o_s_rdy(o_s_rdy), .i_s_rdata(i_s_rdata), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic go();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr();
    i_m0_addr = 0; i_m0_wdata = 0; i_m0_wrcs = 0; i_m0_mask = 0; i_m0_req = 0; i_m0_rdy = 0;
    i_m1_addr = 0; i_m1_wdata = 0; i_m1_wrcs = 0; i_m1_mask = 0; i_m1_req = 0; i_m1_rdy = 0;
    i_s_gnt = 0; i_s_rsp = 0; i_s_rdata = 0;
  endtask

  // Transaction-level model: one transfer in flight, who owns it, who was served last, BUSY age.
  bit m_busy;
  int m_own, m_last, m_age;

  function automatic int pick(bit r0, bit r1, int last_served);
    if (r0 && r1) return 1 - last_served;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_busy = 0; m_own = 0; m_last = 1; m_age = 0;
    end else if (!m_busy) begin
      int w;
      w = pick(i_m0_req, i_m1_req, m_last);
      if (w >= 0 && i_s_gnt) begin
        m_busy = 1; m_own = w; m_last = w; m_age = 0;
      end
    end else begin
      bit rdy;
      rdy = (m_own == 1) ? i_m1_rdy : i_m0_rdy;
      if (i_s_rsp && rdy) m_busy = 0;
      else if (TO != 0 && m_age == TO - 1 && !i_s_rsp) m_busy = 0;
      else if (m_age < 255) m_age++;
    end
  end

  always @(negedge i_clk) begin
    bit e_sreq, e_g0, e_g1, e_r0, e_r1, e_rdy, e_err;
    int w;
    e_sreq = 0; e_g0 = 0; e_g1 = 0; e_r0 = 0; e_r1 = 0; e_rdy = 0; e_err = 0;
    w = pick(i_m0_req, i_m1_req, m_last);
    if (!i_rst) begin
      if (!m_busy) begin
        e_sreq = (w >= 0);
        e_g0 = (w == 0) && i_s_gnt;
        e_g1 = (w == 1) && i_s_gnt;
      end else begin
        e_r0 = (m_own == 0) && i_s_rsp;
        e_r1 = (m_own == 1) && i_s_rsp;
        e_rdy = (m_own == 1) ? i_m1_rdy : i_m0_rdy;
        e_err = (TO != 0) && (m_age == TO - 1) && !i_s_rsp;
      end
    end
    chk("mdl_s_req", o_s_req, e_sreq);
    chk("mdl_m0_gnt", o_m0_gnt, e_g0);
    chk("mdl_m1_gnt", o_m1_gnt, e_g1);
    chk("mdl_m0_rsp", o_m0_rsp, e_r0);
    chk("mdl_m1_rsp", o_m1_rsp, e_r1);
    chk("mdl_s_rdy", o_s_rdy, e_rdy);
    chk("mdl_err", o_err, e_err);
    chk("mdl_rdata", o_m_rdata, i_s_rdata);
    if (e_sreq) begin
      chk("mdl_s_addr", o_s_addr, (w == 1) ? i_m1_addr : i_m0_addr);
      chk("mdl_s_wdata", o_s_wdata, (w == 1) ? i_m1_wdata : i_m0_wdata);
      chk("mdl_s_wrcs", o_s_wrcs, (w == 1) ? i_m1_wrcs : i_m0_wrcs);
      chk("mdl_s_mask", o_s_mask, (w == 1) ? i_m1_mask : i_m0_mask);
    end
  end

  initial begin
    clr();
    i_rst = 1;
    // Reset with every handshake input active: outputs must still be gated low.
    i_m0_req = 1; i_m1_req = 1; i_s_gnt = 1; i_s_rsp = 1; i_m0_rdy = 1; i_m1_rdy = 1;
    repeat (2) go();
    @(negedge i_clk);
    chk("rst_s_req", o_s_req, 0);
    chk("rst_gnt0", o_m0_gnt, 0);
    chk("rst_gnt1", o_m1_gnt, 0);
    chk("rst_rsp0", o_m0_rsp, 0);
    chk("rst_s_rdy", o_s_rdy, 0);
    chk("rst_err", o_err, 0);
    go(); i_rst = 0; clr();

    // Single m0 read with response in the third BUSY cycle.
    i_m0_req = 1; i_m0_addr = 32'h100; i_s_gnt = 1;
    @(negedge i_clk);
    chk("t1_gnt0", o_m0_gnt, 1);
    chk("t1_gnt1", o_m1_gnt, 0);
    chk("t1_addr", o_s_addr, 32'h100);
    go(); i_m0_req = 0; i_s_gnt = 0; i_m0_rdy = 1;
    @(negedge i_clk);
    chk("t1_busy_rsp0", o_m0_rsp, 0);
    go(); go();
    i_s_rsp = 1; i_s_rdata = 32'hDEADBEEF;
    @(negedge i_clk);
    chk("t1_rsp0", o_m0_rsp, 1);
    chk("t1_rsp1", o_m1_rsp, 0);
    chk("t1_rdata", o_m_rdata, 32'hDEADBEEF);
    go(); i_s_rsp = 0;
    @(negedge i_clk);
    chk("t1_idle_rsp0", o_m0_rsp, 0);
    go(); clr();

    // Continuous contention after reset: m0, m1, m0, m1 with an IDLE gap each time.
    i_rst = 1; go(); i_rst = 0;
    i_m0_req = 1; i_m1_req = 1; i_s_gnt = 1; i_s_rsp = 1; i_m0_rdy = 1; i_m1_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("rr_gnt0", o_m0_gnt, (i % 4 == 0) ? 1 : 0);
      chk("rr_gnt1", o_m1_gnt, (i % 4 == 2) ? 1 : 0);
      go();
    end
    clr();
    go();

    // m1 write; m0 must wait until the IDLE cycle after m1 completes.
    i_rst = 1; go(); i_rst = 0;
    i_m1_req = 1; i_m1_wrcs = 1; i_m1_mask = 4'h3; i_m1_wdata = 32'h1234; i_m1_addr = 32'h200; i_s_gnt = 1;
    @(negedge i_clk);
    chk("wr_gnt1", o_m1_gnt, 1);
    chk("wr_wrcs", o_s_wrcs, 1);
    chk("wr_mask", o_s_mask, 4'h3);
    chk("wr_wdata", o_s_wdata, 32'h1234);
    go(); i_m1_req = 0; i_m0_req = 1; i_m0_addr = 32'h300; i_m1_rdy = 1;
    @(negedge i_clk);
    chk("wr_busy_gnt0", o_m0_gnt, 0);
    chk("wr_busy_sreq", o_s_req, 0);
    go(); i_s_rsp = 1;
    @(negedge i_clk);
    chk("wr_rsp1", o_m1_rsp, 1);
    chk("wr_done_gnt0", o_m0_gnt, 0);
    go(); i_s_rsp = 0;
    @(negedge i_clk);
    chk("wr_next_gnt0", o_m0_gnt, 1);
    chk("wr_next_addr", o_s_addr, 32'h300);
    go(); i_m0_req = 0; i_s_gnt = 0; i_s_rsp = 1; i_m0_rdy = 1;
    go(); clr();

    // Slave never answers: abort on the fourth BUSY cycle.
    i_m0_req = 1; i_s_gnt = 1;
    go(); i_m0_req = 0; i_s_gnt = 0; i_m0_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("to_err", o_err, (i == 3) ? 1 : 0);
      chk("to_rsp0", o_m0_rsp, 0);
      go();
    end
    i_m1_req = 1; i_s_gnt = 1;
    @(negedge i_clk);
    chk("to_after_err", o_err, 0);
    chk("to_idle_gnt1", o_m1_gnt, 1);
    go(); i_m1_req = 0; i_s_gnt = 0; i_s_rsp = 1; i_m1_rdy = 1;
    go(); clr();

    // Response exactly at expiry completes normally.
    i_m0_req = 1; i_s_gnt = 1;
    go(); i_m0_req = 0; i_s_gnt = 0; i_m0_rdy = 1;
    repeat (3) go();
    i_s_rsp = 1;
    @(negedge i_clk);
    chk("tie_err", o_err, 0);
    chk("tie_rsp0", o_m0_rsp, 1);
    go(); i_s_rsp = 0; i_m1_req = 1; i_s_gnt = 1;
    @(negedge i_clk);
    chk("tie_idle_gnt1", o_m1_gnt, 1);
    go(); i_m1_req = 0; i_s_gnt = 0; i_s_rsp = 1; i_m1_rdy = 1;
    go(); clr();

    // Reset two cycles into BUSY, then a late response.
    i_m1_req = 1; i_s_gnt = 1;
    go(); i_m1_req = 0; i_s_gnt = 0;
    go();
    #2 i_rst = 1; i_m0_req = 1; i_s_gnt = 1; i_s_rsp = 1; i_m1_rdy = 1;
    #1;
    chk("mid_rst_rsp1", o_m1_rsp, 0);
    chk("mid_rst_gnt0", o_m0_gnt, 0);
    chk("mid_rst_sreq", o_s_req, 0);
    chk("mid_rst_s_rdy", o_s_rdy, 0);
    go(); i_rst = 0; i_m0_req = 0; i_s_gnt = 0;
    @(negedge i_clk);
    chk("late_rsp1", o_m1_rsp, 0);
    chk("late_rsp0", o_m0_rsp, 0);
    chk("late_s_rdy", o_s_rdy, 0);
    chk("late_err", o_err, 0);
    go(); clr();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      i_rst      = ($urandom_range(0, 299) == 0);
      i_m0_req   = ($urandom_range(0, 9) < 6);
      i_m1_req   = ($urandom_range(0, 9) < 6);
      i_m0_rdy   = ($urandom_range(0, 9) < 7);
      i_m1_rdy   = ($urandom_range(0, 9) < 7);
      i_s_gnt    = ($urandom_range(0, 1) == 1);
      i_s_rsp    = ($urandom_range(0, 9) < 3);
      i_m0_addr  = $urandom; i_m0_wdata = $urandom;
      i_m1_addr  = $urandom; i_m1_wdata = $urandom;
      i_m0_wrcs  = 1'($urandom_range(0, 1)); i_m1_wrcs = 1'($urandom_range(0, 1));
      i_m0_mask  = 4'($urandom_range(0, 15)); i_m1_mask = 4'($urandom_range(0, 15));
      i_s_rdata  = $urandom;
      go();
    end
    i_rst = 0; clr();
    go();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
